// File: rtl/irq_controller.sv
// Masked fixed-priority interrupt controller feeding the ID-stage IRQ input.
// Define IRQ_EDGE_EN for edge-latched PENDING (W1C); default is level mode.
module irq_controller #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               supervised,
  input  logic               irq_taken,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    winner;
  logic               any;
  logic               en;
  logic               sup_q;
  logic               in_service;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      sup_q <= 1'b0;
    end else begin
      src_q <= irq_src;
      sup_q <= supervised;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      en   <= 1'b0;
    end else if (reg_we) begin
      if (reg_addr == 2'd0) mask <= reg_wdata[NUM_SRC-1:0];
      if (reg_addr == 2'd3) en   <= reg_wdata[0];
    end
  end

`ifdef IRQ_EDGE_EN
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;

  always_comb begin
    rise = src_q & ~src_d;
    clr  = '0;
    if (reg_we && reg_addr == 2'd1)
      clr = reg_wdata[NUM_SRC-1:0];
    if (irq_taken && state == REQ)
      clr = clr | (NUM_SRC'(1) << irq_id);
  end

  // A new edge outranks a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_d  <= '0;
      pend_q <= '0;
    end else begin
      src_d  <= src_q;
      pend_q <= (pend_q & ~clr) | rise;
    end
  end

  assign pending = pend_q;
`else
  assign pending = src_q;
`endif

  assign eligible = pending & mask & {NUM_SRC{en}};
  assign any      = |eligible;

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (eligible[i]) winner = ID_W'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any && !supervised) state_nx = REQ;
      REQ:     if (irq_taken) state_nx = SERVICE;
      SERVICE: if (sup_q && !supervised) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    irq        = (state == REQ);
    in_service = (state == SERVICE);
  end

  always_ff @(posedge clk) begin
    if (reset)
      irq_id <= '0;
    else if (state == IDLE && state_nx == REQ)
      irq_id <= winner;
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      2'd0: reg_rdata = 32'(mask);
      2'd1: reg_rdata = 32'(pending);
      2'd2: begin
        reg_rdata     = 32'(irq_id);
        reg_rdata[31] = in_service;
      end
      2'd3: reg_rdata = {31'b0, en};
      default: reg_rdata = '0;
    endcase
  end

endmodule
